// File: rtl/reg_access_arb.sv
// Round-robin arbiter for two masters sharing a bit-sliced register bank.
// Writes run as setup/strobe/hold on wrb; reads capture rdout, and both end with a one-cycle ack.
module reg_access_arb #(
    parameter int bus_width = 15,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic [1:0]                   req,
    input  logic [1:0]                   req_we,
    input  logic [2*ADDR_W-1:0]          req_addr,
    input  logic [2*(bus_width+1)-1:0]   req_wdata,
    output logic [1:0]                   ack,
    output logic [bus_width:0]           rdata,
    output logic                         addr_err,
    output logic                         busy,
    output logic [NUM_REGS-1:0]          reg_sel,
    output logic [bus_width:0]           din,
    output logic                         wrb,
    input  logic [bus_width:0]           rdout
);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD, R_SEL, R_CAP, DONE
    } state_t;

    state_t                state, state_next;
    logic                  winner, last_gnt, we_q, grant;
    logic [ADDR_W-1:0]     addr_q;
    logic                  in_range;
    logic [NUM_REGS-1:0]   sel_decode;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        grant = req[1];
        if (req == 2'b11)
            grant = ~last_gnt;
    end

    always_comb begin
        in_range   = int'(addr_q) < NUM_REGS;
        sel_decode = '0;
        for (int i = 0; i < NUM_REGS; i++)
            sel_decode[i] = (int'(addr_q) == i);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            winner   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din      <= '0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req != 2'b00) begin
                winner   <= grant;
                last_gnt <= grant;
                we_q     <= req_we[grant];
                addr_q   <= grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                if (req_we[grant])
                    din <= grant ? req_wdata[2*(bus_width+1)-1:bus_width+1]
                                 : req_wdata[bus_width:0];
            end
            // Out-of-range reads select no slice, so return zero rather than a floating bus.
            if (state == R_CAP)
                rdata <= in_range ? rdout : '0;
        end
    end

    always_comb begin
        state_next = state;
        ack        = 2'b00;
        addr_err   = 1'b0;
        wrb        = 1'b1;
        reg_sel    = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (req != 2'b00)
                    state_next = req_we[grant] ? W_SETUP : R_SEL;
            end
            W_SETUP: begin
                reg_sel    = sel_decode;
                state_next = W_STROBE;
            end
            W_STROBE: begin
                reg_sel    = sel_decode;
                wrb        = 1'b0;
                state_next = W_HOLD;
            end
            W_HOLD: begin
                reg_sel    = sel_decode;
                state_next = DONE;
            end
            R_SEL: begin
                reg_sel    = sel_decode;
                state_next = R_CAP;
            end
            R_CAP: begin
                reg_sel    = sel_decode;
                state_next = DONE;
            end
            DONE: begin
                ack[winner] = 1'b1;
                addr_err    = ~in_range;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
